// File: rtl/pkt_rx_store_fwd.sv
// pkt_rx_store_fwd
// Store-and-forward packet receiver. Packets arrive on a Val/Sop/Eop/Mod bus.
// The first beat of each packet carries a 16-bit byte length in its top bits.
// Each packet is written into a block-RAM buffer. It is committed only when
// its beat count and Eop Mod agree with that length. A failing packet is
// rewound, so it never reaches the output. Committed packets are replayed on
// an identical output bus, with Rdy back-pressure.
//
// Ports:
//   Clk, Rst        clock; synchronous active-high reset
//   InBus_*         input packet bus; InBus_Rdy is registered
//   InBus_Error     one-cycle error pulse; Err_Code holds the last cause
//                   (1 bad header, 2 length mismatch, 3 too long,
//                    4 Sop inside packet, 5 beat without Sop)
//   OutBus_*        output packet bus; OutBus_Rdy is downstream ready
//   Pkt_Avail       at least one committed packet not yet read
//
// Optional macro RX_STATS_EN adds the saturating counters Pkt_Ok_Cnt and
// Pkt_Err_Cnt.
module pkt_rx_store_fwd #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int MOD_W      = DATA_WIDTH / 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic                  InBus_Rdy,
  input  logic                  InBus_Val,
  input  logic                  InBus_Sop,
  input  logic                  InBus_Eop,
  input  logic [MOD_W-1:0]      InBus_Mod,
  input  logic [DATA_WIDTH-1:0] InBus_Dat,
  output logic                  InBus_Error,
  output logic [2:0]            Err_Code,
  input  logic                  OutBus_Rdy,
  output logic                  OutBus_Val,
  output logic                  OutBus_Sop,
  output logic                  OutBus_Eop,
  output logic [MOD_W-1:0]      OutBus_Mod,
  output logic [DATA_WIDTH-1:0] OutBus_Dat,
  output logic                  Pkt_Avail
`ifdef RX_STATS_EN
  ,
  output logic [31:0]           Pkt_Ok_Cnt,
  output logic [31:0]           Pkt_Err_Cnt
`endif
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BW     = $clog2(BYTES);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int PW     = ADDR_WIDTH + 1;
  localparam int WORD_W = DATA_WIDTH + MOD_W + 1;  // {eop, mod, data}
  localparam logic [16:0] MAX_LEN = 17'(DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  wr_state_t         state_q, state_d;
  logic [PW-1:0]     wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d;
  logic [15:0]       rem_q, rem_d;
  logic              err_q, err_d;
  logic [2:0]        code_q, code_d;
  logic              rdy_q, rdy_d;
  logic              avail_q, avail_d;
  logic              out_val_q, out_val_d, out_sop_q, out_sop_d;
  logic              first_q, first_d;
  logic [WORD_W-1:0] out_word_q;

  logic                  beat, we, commit, sop_as_new, rd_en;
  logic [PW-1:0]         base;
  logic [15:0]           hdr_len;
  logic [DATA_WIDTH-1:0] wr_dat;

  assign beat    = InBus_Val && rdy_q;
  assign hdr_len = InBus_Dat[DATA_WIDTH-1 -: 16];

  // Byte 0 is the most significant byte. On an Eop beat with Mod != 0,
  // bytes at index >= Mod are stored as zero.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
    assign wr_dat[DATA_WIDTH-1-8*gi -: 8] =
      (!InBus_Eop || InBus_Mod == '0 || MOD_W'(gi) < InBus_Mod) ?
      InBus_Dat[DATA_WIDTH-1-8*gi -: 8] : 8'h00;
  end

  // Write-side FSM. A Sop seen in RECV first rewinds to cmt_q. The same
  // beat is then qualified as a fresh header, writing from 'base'.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    cmt_d      = cmt_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    code_d     = code_q;
    we         = 1'b0;
    commit     = 1'b0;
    sop_as_new = 1'b0;
    base       = wr_q;
    if (beat) begin
      case (state_q)
        IDLE: begin
          if (InBus_Sop) sop_as_new = 1'b1;
          else begin err_d = 1'b1; code_d = 3'd5; end
        end
        RECV: begin
          if (InBus_Sop) begin
            err_d = 1'b1; code_d = 3'd4;
            base = cmt_q; wr_d = cmt_q; sop_as_new = 1'b1;
          end else if (InBus_Eop) begin
            // rem counts bytes still owed, so rem mod BYTES equals L mod BYTES.
            if (rem_q <= 16'(BYTES) && InBus_Mod == MOD_W'(rem_q[BW-1:0])) begin
              we = 1'b1; wr_d = wr_q + PW'(1); cmt_d = wr_q + PW'(1);
              commit = 1'b1; state_d = IDLE;
            end else begin
              err_d = 1'b1; code_d = 3'd2; wr_d = cmt_q; state_d = IDLE;
            end
          end else if (rem_q <= 16'(BYTES)) begin
            err_d = 1'b1; code_d = 3'd2; wr_d = cmt_q; state_d = DROP;
          end else begin
            we = 1'b1; wr_d = wr_q + PW'(1); rem_d = rem_q - 16'(BYTES);
          end
        end
        DROP: if (InBus_Eop) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (sop_as_new) begin
        if (hdr_len < 16'd2 || (!InBus_Eop && InBus_Mod != '0)) begin
          err_d = 1'b1; code_d = 3'd1; state_d = InBus_Eop ? IDLE : DROP;
        end else if ({1'b0, hdr_len} > MAX_LEN) begin
          err_d = 1'b1; code_d = 3'd3; state_d = InBus_Eop ? IDLE : DROP;
        end else if (InBus_Eop) begin
          if (hdr_len <= 16'(BYTES) && InBus_Mod == MOD_W'(hdr_len[BW-1:0])) begin
            we = 1'b1; wr_d = base + PW'(1); cmt_d = base + PW'(1);
            commit = 1'b1;
          end else begin
            err_d = 1'b1; code_d = 3'd2;
          end
          state_d = IDLE;
        end else if (hdr_len <= 16'(BYTES)) begin
          // The whole packet fits one beat, but the packet continues.
          err_d = 1'b1; code_d = 3'd2; state_d = DROP;
        end else begin
          we = 1'b1; wr_d = base + PW'(1);
          rem_d = hdr_len - 16'(BYTES); state_d = RECV;
        end
      end
    end
  end

  // Read side. A word is fetched only when it is committed and the output
  // register is free or draining, so a stalled beat stays put.
  assign rd_en = (rd_q != cmt_q) && (!out_val_q || OutBus_Rdy);

  always_comb begin
    rd_d      = rd_en ? rd_q + PW'(1) : rd_q;
    first_d   = rd_en ? 1'b0 : first_q;
    // out_word_q still holds the previous word, so its Eop marks the new Sop.
    out_sop_d = rd_en ? (first_q || out_word_q[WORD_W-1]) : out_sop_q;
    out_val_d = rd_en ? 1'b1 : (OutBus_Rdy ? 1'b0 : out_val_q);
    // A two-word free margin absorbs the one write that lands while Rdy lags.
    rdy_d     = (wr_q - rd_q) <= PW'(DEPTH - 2);
    avail_d   = (cmt_q != rd_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      cmt_q     <= '0;
      rd_q      <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= 3'd0;
      rdy_q     <= 1'b0;
      avail_q   <= 1'b0;
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      cmt_q     <= cmt_d;
      rd_q      <= rd_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      code_q    <= code_d;
      rdy_q     <= rdy_d;
      avail_q   <= avail_d;
      out_val_q <= out_val_d;
      out_sop_q <= out_sop_d;
      first_q   <= first_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (we && !Rst)
      mem[base[ADDR_WIDTH-1:0]] <= {InBus_Eop, (InBus_Eop ? InBus_Mod : MOD_W'(0)), wr_dat};
  end

  // The RAM read register is also the output data register.
  always_ff @(posedge Clk) begin
    if (Rst)        out_word_q <= '0;
    else if (rd_en) out_word_q <= mem[rd_q[ADDR_WIDTH-1:0]];
  end

  assign InBus_Rdy   = rdy_q;
  assign InBus_Error = err_q;
  assign Err_Code    = code_q;
  assign Pkt_Avail   = avail_q;
  assign OutBus_Val  = out_val_q;
  assign OutBus_Sop  = out_sop_q;
  assign OutBus_Eop  = out_word_q[WORD_W-1];
  assign OutBus_Mod  = out_word_q[DATA_WIDTH +: MOD_W];
  assign OutBus_Dat  = out_word_q[DATA_WIDTH-1:0];

`ifdef RX_STATS_EN
  logic [31:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (commit && ok_cnt_q != '1) ok_cnt_d  = ok_cnt_q + 32'd1;
    if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Pkt_Ok_Cnt  = ok_cnt_q;
  assign Pkt_Err_Cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_rx_store_fwd.sv
// Directed bench for pkt_rx_store_fwd (DATA_WIDTH=64, ADDR_WIDTH=4).
// The packet-level model turns each sent packet into either a list of
// expected output beats or an expected error code. A compare process checks
// the outputs against that list on every transfer or stall.
module tb_pkt_rx_store_fwd;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int MW = DW / 8;

  logic          Clk, Rst;
  logic          InBus_Rdy, InBus_Val, InBus_Sop, InBus_Eop;
  logic [MW-1:0] InBus_Mod;
  logic [DW-1:0] InBus_Dat;
  logic          InBus_Error;
  logic [2:0]    Err_Code;
  logic          OutBus_Rdy, OutBus_Val, OutBus_Sop, OutBus_Eop;
  logic [MW-1:0] OutBus_Mod;
  logic [DW-1:0] OutBus_Dat;
  logic          Pkt_Avail;
`ifdef RX_STATS_EN
  logic [31:0]   Pkt_Ok_Cnt, Pkt_Err_Cnt;
`endif

  pkt_rx_store_fwd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .InBus_Rdy(InBus_Rdy), .InBus_Val(InBus_Val), .InBus_Sop(InBus_Sop),
    .InBus_Eop(InBus_Eop), .InBus_Mod(InBus_Mod), .InBus_Dat(InBus_Dat),
    .InBus_Error(InBus_Error), .Err_Code(Err_Code),
    .OutBus_Rdy(OutBus_Rdy), .OutBus_Val(OutBus_Val), .OutBus_Sop(OutBus_Sop),
    .OutBus_Eop(OutBus_Eop), .OutBus_Mod(OutBus_Mod), .OutBus_Dat(OutBus_Dat),
    .Pkt_Avail(Pkt_Avail)
`ifdef RX_STATS_EN
    , .Pkt_Ok_Cnt(Pkt_Ok_Cnt), .Pkt_Err_Cnt(Pkt_Err_Cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
    logic [7:0]  mod;
  } beat_t;

  beat_t exp_q[$];
  int    err_q[$];
  int    checks = 0;
  int    errors = 0;
  int    tot_wait = 0;
  int    acc_beats = 0;
  time   last_acc_time = 0;
  time   last_sop_time = 0;
  logic [63:0] last_eop_dat = '0;
  logic [7:0]  last_eop_mod = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte 0 is the most significant byte; bytes at index >= m are cleared.
  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input int m);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 8; i++)
      if (m != 0 && i >= m) r[63-8*i -: 8] = 8'h00;
    return r;
  endfunction

  task automatic drive_beat(input logic sop, input logic eop, input int mod,
                            input logic [63:0] dat, output int waited);
    logic acc;
    InBus_Val = 1'b1; InBus_Sop = sop; InBus_Eop = eop;
    InBus_Mod = 8'(mod); InBus_Dat = dat;
    waited = 0;
    forever begin
      @(negedge Clk);
      acc = InBus_Rdy;
      if (acc) last_acc_time = $time;
      @(posedge Clk); #1;
      if (acc) begin acc_beats++; break; end
      waited++;
      if (waited > 1000) begin
        checks++; errors++;
        $display("FAIL in_accept_timeout: got no InBus_Rdy in %0d cycles expected accept", waited);
        break;
      end
    end
  endtask

  // Packet-level model: a packet is delivered only if it ends in Eop, has
  // 2 <= L <= 128, uses ceil(L/8) beats and its Eop Mod equals L mod 8.
  // Otherwise the table supplies the cause code to expect.
  task automatic send_pkt(input int len, input int nb, input bit with_eop,
                          input int mod, input int tag, input int code);
    bit ok;
    beat_t b;
    logic [63:0] d;
    logic e;
    int m, w;
    ok = with_eop && len >= 2 && len <= 128 && nb == (len + 7) / 8 && mod == len % 8;
    for (int k = 0; k < nb; k++) begin
      d = {8'(tag), 8'(k), 48'h0123_4567_89AB};
      if (k == 0) d[63:48] = 16'(len);
      e = with_eop && (k == nb - 1);
      m = e ? mod : 0;
      if (ok) begin
        b.dat = e ? mask_bytes(d, m) : d;
        b.sop = (k == 0); b.eop = e; b.mod = 8'(m);
        exp_q.push_back(b);
      end
      if (k == 0 && !ok && code != 0) err_q.push_back(code);
      drive_beat(k == 0, e, m, d, w);
      tot_wait += w;
    end
    InBus_Val = 1'b0; InBus_Sop = 1'b0; InBus_Eop = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 || OutBus_Val) begin
      @(posedge Clk); #2;
      n++;
      if (n > 600) begin
        checks++; errors++;
        $display("FAIL %s_drain_timeout: got %0d beats pending expected 0", nm, exp_q.size());
        break;
      end
    end
  endtask

  // Compare process: on every transfer, check the beat against the model.
  // On every stall, check that the outputs hold. On every error pulse,
  // check Err_Code against the expected cause.
  initial begin : compare
    logic        prev_stall;
    logic [73:0] prev_bus, cur_bus;
    beat_t       e;
    int          ec;
    prev_stall = 1'b0;
    prev_bus = '0;
    forever begin
      @(negedge Clk);
      if (Rst) begin prev_stall = 1'b0; continue; end
      cur_bus = {OutBus_Sop, OutBus_Eop, OutBus_Mod, OutBus_Dat};
      if (prev_stall) begin
        checks++;
        if (!OutBus_Val || cur_bus !== prev_bus) begin
          errors++;
          $display("FAIL out_hold: got val=%b bus=%h expected val=1 bus=%h",
                   OutBus_Val, cur_bus, prev_bus);
        end
      end
      if (OutBus_Val && OutBus_Rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got beat %h expected no beat", OutBus_Dat);
        end else begin
          e = exp_q.pop_front();
          if (OutBus_Dat !== e.dat || OutBus_Sop !== e.sop || OutBus_Eop !== e.eop ||
              (e.eop && OutBus_Mod !== e.mod)) begin
            errors++;
            $display("FAIL out_beat: got dat=%h sop=%b eop=%b mod=%0d expected dat=%h sop=%b eop=%b mod=%0d",
                     OutBus_Dat, OutBus_Sop, OutBus_Eop, OutBus_Mod, e.dat, e.sop, e.eop, e.mod);
          end
        end
        $display("out beat dat=%h sop=%b eop=%b mod=%0d", OutBus_Dat, OutBus_Sop, OutBus_Eop, OutBus_Mod);
        if (OutBus_Sop) last_sop_time = $time;
        if (OutBus_Eop) begin last_eop_dat = OutBus_Dat; last_eop_mod = OutBus_Mod; end
      end
      prev_stall = OutBus_Val && !OutBus_Rdy;
      prev_bus = cur_bus;
      if (InBus_Error) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: got code %0d expected no error", Err_Code);
        end else begin
          ec = err_q.pop_front();
          if (Err_Code !== 3'(ec)) begin
            errors++;
            $display("FAIL err_code: got %0d expected %0d", Err_Code, ec);
          end
        end
        $display("error pulse code=%0d", Err_Code);
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_val"},   OutBus_Val, 0);
    chk({nm, "_sop"},   OutBus_Sop, 0);
    chk({nm, "_eop"},   OutBus_Eop, 0);
    chk({nm, "_mod"},   OutBus_Mod, 0);
    chk({nm, "_dat"},   OutBus_Dat, 0);
    chk({nm, "_rdy"},   InBus_Rdy, 0);
    chk({nm, "_err"},   InBus_Error, 0);
    chk({nm, "_code"},  Err_Code, 0);
    chk({nm, "_avail"}, Pkt_Avail, 0);
  endtask

  initial begin : main
    time eop_t;
    int  w, fall_beats, outs;
    bit  fell;
    Rst = 1'b1; InBus_Val = 1'b0; InBus_Sop = 1'b0; InBus_Eop = 1'b0;
    InBus_Mod = '0; InBus_Dat = '0; OutBus_Rdy = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // 1: L=20, three beats, Eop Mod=4.
    send_pkt(20, 3, 1, 4, 8'hC0, 0);
    eop_t = last_acc_time;
    wait_drain("t1");
    chk("t1_eop_dat", last_eop_dat, 64'hC002_0123_0000_0000);
    chk("t1_eop_mod", last_eop_mod, 4);
    chk("t1_sop_latency", 64'(last_sop_time - eop_t), 20);

    // 2: L=20 but Eop on beat 2, then a good packet.
    send_pkt(20, 2, 1, 4, 8'h20, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("t2_pkt_avail", Pkt_Avail, 0);
    end
    chk("t2_err_code", Err_Code, 2);
    @(posedge Clk); #1;
    send_pkt(20, 3, 1, 4, 8'h21, 0);
    wait_drain("t2");

    // 3: L=200 is too long; all 25 beats accepted and dropped.
    tot_wait = 0;
    send_pkt(200, 25, 1, 0, 8'h30, 3);
    chk("t3_no_backpressure", tot_wait, 0);
    repeat (6) @(negedge Clk);
    chk("t3_err_code", Err_Code, 3);
    chk("t3_pkt_avail", Pkt_Avail, 0);
    @(posedge Clk); #1;

    // 4: fill with OutBus_Rdy=0, then toggle Rdy and drain.
    OutBus_Rdy = 1'b0;
    acc_beats = 0;
    fell = 1'b0;
    fall_beats = 0;
    fork
      begin
        for (int p = 0; p < 6; p++) send_pkt(20, 3, 1, 4, 8'h40 + p, 0);
      end
      begin
        for (int c = 0; c < 300; c++) begin
          @(negedge Clk);
          if (!InBus_Rdy) begin
            fell = 1'b1; fall_beats = acc_beats;
            chk("t4_pkt_avail_full", Pkt_Avail, 1);
            break;
          end
        end
        for (int i = 0; i < 10; i++) begin
          @(posedge Clk); #1;
          OutBus_Rdy = i[0];
        end
        @(posedge Clk); #1;
        OutBus_Rdy = 1'b1;
      end
    join
    chk("t4_rdy_fell", fell, 1);
    chk("t4_fill_level_ok", (fall_beats >= 15 && fall_beats <= 17), 1);
    wait_drain("t4");

    // 5: Sop arrives on beat 2 of a 4-beat packet.
    send_pkt(32, 1, 0, 0, 8'h50, 4);
    send_pkt(24, 3, 1, 0, 8'h51, 0);
    wait_drain("t5");
    chk("t5_err_code", Err_Code, 4);

    // 6: reset mid-packet with two committed packets buffered.
    OutBus_Rdy = 1'b0;
    send_pkt(8, 1, 1, 0, 8'h60, 0);
    send_pkt(16, 2, 1, 0, 8'h61, 0);
    drive_beat(1'b1, 1'b0, 0, {16'd24, 48'h0}, w);
    InBus_Val = 1'b0; InBus_Sop = 1'b0;
    repeat (2) @(negedge Clk);
    chk("t6_pkt_avail_before", Pkt_Avail, 1);
    @(posedge Clk); #1;
    exp_q.delete();
    Rst = 1'b1;
    @(posedge Clk); #1;
    check_reset_outputs("t6_reset");
    Rst = 1'b0;
    OutBus_Rdy = 1'b1;
    outs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (OutBus_Val) outs++;
    end
    chk("t6_no_output_after_reset", outs, 0);
    @(posedge Clk); #1;
    send_pkt(20, 3, 1, 4, 8'h62, 0);
    wait_drain("t6");

    repeat (4) @(posedge Clk);
    #2;
    chk("end_exp_queue_empty", exp_q.size(), 0);
    chk("end_err_queue_empty", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_rx_store_fwd.md
Name: pkt_rx_store_fwd

Overview:
Parametrised store-and-forward packet receiver, successor to the single-FIFO receive stage. Accepts Val/Sop/Eop/Mod bus packets whose first beat carries a 16-bit byte-length header. Writes each packet into an internal buffer of configurable width and depth, and commits it only when the length check passes; failing packets are rewound and never appear downstream. Commits packets are replayed on an identical output bus with Rdy back-pressure.

Parameters:
DATA_WIDTH, 64, bus width in bits; legal values 16, 32, 64.
ADDR_WIDTH, 9, buffer depth = 2**ADDR_WIDTH words.
MOD_W, DATA_WIDTH/8, width of Mod fields.

Ports:
Clk  in  1  clock
Rst  in  1  reset
InBus_Rdy  out  1  registered ready
InBus_Val / InBus_Sop / InBus_Eop  in  1  valid, start, end of packet
InBus_Mod  in  MOD_W  valid bytes on Eop beat; 0 = all bytes valid
InBus_Dat  in  DATA_WIDTH  data; header in bits [DATA_WIDTH-1:DATA_WIDTH-16] of Sop beat
InBus_Error  out  1  one-cycle error pulse
Err_Code  out  3  cause of last error; held until next error
OutBus_Rdy  in  1  downstream ready
OutBus_Val / OutBus_Sop / OutBus_Eop  out  1  output framing
OutBus_Mod  out  MOD_W  valid bytes on Eop beat
OutBus_Dat  out  DATA_WIDTH  output data
Pkt_Avail  out  1  at least one committed, unread packet

Behaviour:
- Rst is synchronous, active-high, clock Clk. On reset:
  - wr_ptr, cmt_ptr and rd_ptr clear to 0; buffered data is discarded, including a packet in flight.
  - All outputs are 0, Err_Code = 0, and the write FSM enters IDLE.
- A beat transfers when Val && Rdy on either bus.
- InBus_Rdy is registered and is 1 when free words (DEPTH - (wr_ptr - rd_ptr)) >= 2. The one-cycle lag can never overflow the buffer.
- Each memory word stores data, an Eop flag and Mod. Data bytes beyond Mod on the Eop beat are written as zero.
- Header L = packet byte count including header. Expected Eop-beat Mod = L mod DATA_WIDTH/8.
- Write FSM:
  - IDLE:
    - Sop beat with L < 2, or a Sop-only beat with Mod != 0 -> error 1, go to DROP (or stay in IDLE if the beat is also Eop).
    - L > DEPTH*DATA_WIDTH/8 -> error 3, go to DROP.
    - Otherwise write the word, set rem = L - DATA_WIDTH/8, go to RECV. A single-beat packet (Sop+Eop) with matching Mod commits immediately.
    - Val without Sop -> error 5, beat discarded.
  - RECV:
    - Each beat writes one word; rem decrements by DATA_WIDTH/8.
    - Eop with rem <= DATA_WIDTH/8 and Mod matching -> write, set cmt_ptr = wr_ptr+1, go to IDLE.
    - Eop early or Mod mismatch -> error 2, set wr_ptr = cmt_ptr, go to IDLE.
    - rem <= DATA_WIDTH/8 on a non-Eop beat -> error 2, rewind, go to DROP.
    - Sop beat -> error 4, rewind, then process the beat as a new IDLE Sop in the same cycle.
  - DROP: accept and discard beats until an Eop beat, then go to IDLE.
- Read side:
  - Reads only words below cmt_ptr. Memory has 1-cycle read latency and the output is registered.
  - OutBus_Sop is asserted on the first word after reset or after an Eop word.
  - While OutBus_Val && !OutBus_Rdy, all Out* signals are held stable.
  - Latency: with the buffer empty and OutBus_Rdy = 1, the Eop beat accepted in cycle T gives OutBus_Val with Sop in cycle T+2.
- Simultaneous write and read are supported. A commit and a read in the same cycle are independent; the read side sees the new cmt_ptr one cycle later.
- Pointers are ADDR_WIDTH+1 bits; wrap-around is handled by the MSB. Full = pointer difference equals DEPTH.
- Pkt_Avail = (cmt_ptr != rd_ptr), registered.

Optional Feature:
RX_STATS_EN:
- Defined: adds output ports Pkt_Ok_Cnt[31:0] and Pkt_Err_Cnt[31:0].
  - Pkt_Ok_Cnt increments on each commit; Pkt_Err_Cnt increments on each InBus_Error pulse.
  - Both saturate at 2**32-1 and clear on Rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
All scenarios use DATA_WIDTH=64, ADDR_WIDTH=4 (16 words).
1. Packet with L=20, three beats, Eop Mod=4, OutBus_Rdy=1 -> three output beats; Sop on beat 1; Eop with Mod=4 on beat 3; bytes 4..7 of beat 3 are zero; Sop appears at Eop+2.
2. Packet with L=20 but Eop on beat 2 -> InBus_Error pulse, Err_Code=2, no output, Pkt_Avail stays 0, and a following good packet is output intact.
3. Packet with L=200 (>128) -> Err_Code=3; all beats accepted with InBus_Rdy=1 and dropped; no output.
4. 15 words committed with OutBus_Rdy=0 -> InBus_Rdy falls once free < 2. Then OutBus_Rdy toggles 0/1 for 10 cycles -> Out* held stable while stalled, every byte delivered in order, no loss.
5. Sop arrives on beat 2 of a 4-beat packet -> Err_Code=4; the first packet is discarded and the second packet is delivered completely.
6. Rst for 1 cycle mid-packet with 2 committed packets buffered -> all outputs 0, no further output, and the next packet passes normally.
